// File: rtl/uart_baud_gen_if.sv
// Configuration handshake bundle for uart_baud_gen: divisor offer, ready and error pulse.
interface uart_baud_gen_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_div_int, cfg_div_frac,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_div_int, cfg_div_frac,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Programmable UART baud-rate generator: oversample tick, baud tick and bit-rate square wave.
// Runtime divisor (integer + optional fraction) is taken through a valid/ready handshake and
// only swapped in on a bit boundary, or immediately while the generator is disabled.
// Optional feature macro: UART_BAUD_GEN_FRAC_EN enables the fractional accumulator.
module uart_baud_gen #(
  parameter int unsigned SYSTEM_CLK     = 50000000,
  parameter int unsigned UART_BUAD_RATE = 9600,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned FRAC_W         = 4
) (
  input  logic            i_sys_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  uart_baud_gen_if.slave  cfg_if,
  output logic            o_os_tick,
  output logic            o_baud_tick,
  output logic            o_u_clk
);

  localparam int unsigned       OS_W      = $clog2(OVERSAMPLE);
  localparam longint unsigned   DIVISOR   = 64'(UART_BUAD_RATE) * 64'(OVERSAMPLE);
  localparam logic [DIV_W-1:0]  DEF_INT   = DIV_W'(64'(SYSTEM_CLK) / DIVISOR);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_HALF   = OS_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0] r_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic             r_u_clk;
  logic [DIV_W-1:0] r_act_int;
  logic [DIV_W-1:0] r_pend_int;
  logic             r_pend;
  logic             r_err;

  logic             w_os_tick;
  logic             w_baud_tick;
  logic             w_accept;
  logic             w_cfg_ok;
  logic             w_apply;
  logic             w_carry;
  logic [OS_W-1:0]  w_os_next;
  logic [DIV_W-1:0] w_reload;
  logic [DIV_W-1:0] w_new_load;

  assign w_os_tick   = i_en && (r_cnt == '0);
  assign w_baud_tick = w_os_tick && (r_os_cnt == OS_LAST);
  assign w_accept    = cfg_if.cfg_valid && !r_pend;
  assign w_cfg_ok    = (cfg_if.cfg_div_int >= DIV_W'(2));
  // Pending divisor swaps in at a bit boundary, or at once while counting is frozen.
  assign w_apply     = r_pend && (w_baud_tick || !i_en);
  // OVERSAMPLE is a power of two, so the natural wrap is the modulo.
  assign w_os_next   = r_os_cnt + OS_W'(1);
  assign w_reload    = r_act_int - DIV_W'(1) + DIV_W'(w_carry);
  assign w_new_load  = r_pend_int - DIV_W'(1);

`ifdef UART_BAUD_GEN_FRAC_EN
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'((64'(SYSTEM_CLK) << FRAC_W) / DIVISOR);

  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W-1:0] r_act_frac;
  logic [FRAC_W-1:0] r_pend_frac;
  logic [FRAC_W:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
  assign w_carry   = w_acc_sum[FRAC_W];

  // Fractional accumulator: advances on each oversample tick, clears when a new divisor lands.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (w_apply) begin
      r_acc <= '0;
    end else if (w_os_tick) begin
      r_acc <= w_acc_sum[FRAC_W-1:0];
    end
  end

  // Fractional part of the active and pending divisors.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_act_frac  <= DEF_FRAC;
      r_pend_frac <= '0;
    end else begin
      if (w_apply) begin
        r_act_frac <= r_pend_frac;
      end
      if (w_accept && w_cfg_ok) begin
        r_pend_frac <= cfg_if.cfg_div_frac;
      end
    end
  end
`else
  logic [FRAC_W-1:0] w_unused_frac;

  assign w_carry       = 1'b0;
  assign w_unused_frac = cfg_if.cfg_div_frac;
`endif

  // Period down-counter, oversample position and the registered bit-rate clock.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= DEF_INT - DIV_W'(1);
      r_os_cnt <= '0;
      r_u_clk  <= 1'b0;
    end else if (i_en) begin
      if (w_os_tick) begin
        r_cnt    <= w_apply ? w_new_load : w_reload;
        r_os_cnt <= w_os_next;
        r_u_clk  <= (w_os_next < OS_HALF);
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end else if (w_apply) begin
      // Disabled apply restarts the bit phase; o_u_clk keeps its level.
      r_cnt    <= w_new_load;
      r_os_cnt <= '0;
    end
  end

  // Configuration handshake: pending slot, active integer divisor and error pulse.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_act_int  <= DEF_INT;
      r_pend_int <= DEF_INT;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_apply) begin
        r_act_int <= r_pend_int;
        r_pend    <= 1'b0;
      end
      // Accept only happens with the slot empty, so it never races the apply above.
      if (w_accept) begin
        if (w_cfg_ok) begin
          r_pend_int <= cfg_if.cfg_div_int;
          r_pend     <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign cfg_if.cfg_ready = !r_pend;
  assign cfg_if.cfg_err   = r_err;
  assign o_os_tick        = w_os_tick;
  assign o_baud_tick      = w_baud_tick;
  assign o_u_clk          = r_u_clk;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: two instances (OVERSAMPLE 16 and 4) share stimulus and
// are compared every cycle against a tick-schedule reference model, plus directed period checks.
module tb_uart_baud_gen;

  localparam int SYS  = 50000000;
  localparam int BAUD = 9600;
  localparam int F    = 4;

  typedef struct {
    int rem;    // enabled cycles until next oversample tick, counting the current one
    int k;      // tick index since last phase/accumulator restart (mod 2^F)
    int os;     // ticks into the current bit
    bit u;
    bit err;
    bit pend;
    int pint;
    int pfrac;
    int aint;
    int afrac;
  } model_t;

  logic clk = 1'b0;
  logic rst_n, en, valid;
  logic [15:0] dint;
  logic [3:0]  dfrac;
  logic os16, baud16, u16, os4, baud4, u4;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int rel;
  int q16[$];
  int q4_os[$];
  int q4_baud[$];
  bit q4_u[$];
  int u4_base;
  model_t m16, m4;

  always #5 clk = ~clk;

  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus16 ();
  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus4 ();

  assign bus16.cfg_valid    = valid;
  assign bus16.cfg_div_int  = dint;
  assign bus16.cfg_div_frac = dfrac;
  assign bus4.cfg_valid     = valid;
  assign bus4.cfg_div_int   = dint;
  assign bus4.cfg_div_frac  = dfrac;

  uart_baud_gen #(.OVERSAMPLE(16)) u_dut16 (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .cfg_if     (bus16),
    .o_os_tick  (os16),
    .o_baud_tick(baud16),
    .o_u_clk    (u16)
  );

  uart_baud_gen #(.OVERSAMPLE(4)) u_dut4 (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .cfg_if     (bus4),
    .o_os_tick  (os4),
    .o_baud_tick(baud4),
    .o_u_clk    (u4)
  );

  // Number of extra cycles in the period following tick k: how many times k*f/2^F crosses an
  // integer between tick k and k+1.
  function automatic int carry(input int k, input int f);
`ifdef UART_BAUD_GEN_FRAC_EN
    return (((k + 1) * f) >> F) - ((k * f) >> F);
`else
    return 0 * (k + f);
`endif
  endfunction

  function automatic void model_reset(input int os, output model_t m);
    m.aint  = SYS / (BAUD * os);
    m.afrac = ((SYS << F) / (BAUD * os)) % (1 << F);
    m.rem   = m.aint;
    m.k     = 0;
    m.os    = 0;
    m.u     = 1'b0;
    m.err   = 1'b0;
    m.pend  = 1'b0;
    m.pint  = 0;
    m.pfrac = 0;
  endfunction

  function automatic void model_step(input model_t s, input int os, input bit r, input bit e,
                                     input bit v, input int di, input int df, output model_t n);
    bit tick, baud;
    n = s;
    if (!r) begin
      model_reset(os, n);
      return;
    end
    tick  = e && (s.rem == 1);
    baud  = tick && (s.os == os - 1);
    n.err = 1'b0;
    if (e) begin
      if (tick) begin
        n.os = (s.os + 1) % os;
        n.u  = (n.os < os / 2);
        if (baud && s.pend) begin
          n.aint = s.pint; n.afrac = s.pfrac; n.pend = 1'b0; n.rem = s.pint; n.k = 0;
        end else begin
          n.rem = s.aint + carry(s.k, s.afrac);
          n.k   = (s.k + 1) % (1 << F);
        end
      end else begin
        n.rem = s.rem - 1;
      end
    end else if (s.pend) begin
      n.aint = s.pint; n.afrac = s.pfrac; n.pend = 1'b0; n.rem = s.pint; n.k = 0; n.os = 0;
    end
    if (v && !s.pend) begin
      if (di < 2) begin
        n.err = 1'b1;
      end else begin
        n.pend = 1'b1; n.pint = di; n.pfrac = df;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp_dut(input string p, input model_t m, input int os, input logic ot,
                         input logic bt, input logic uc, input logic rdy, input logic er);
    bit et;
    et = en && (m.rem == 1);
    chk({p, "_os_tick"}, ot, et);
    chk({p, "_baud_tick"}, bt, et && (m.os == os - 1));
    chk({p, "_u_clk"}, uc, m.u);
    chk({p, "_cfg_ready"}, rdy, !m.pend);
    chk({p, "_cfg_err"}, er, m.err);
  endtask

  // Inputs are stable from posedge+1; outputs are compared at the falling edge.
  task automatic run_cycle();
    model_t n16, n4;
    @(negedge clk);
    cmp_dut("d16", m16, 16, os16, baud16, u16, bus16.cfg_ready, bus16.cfg_err);
    cmp_dut("d4", m4, 4, os4, baud4, u4, bus4.cfg_ready, bus4.cfg_err);
    if (os16 === 1'b1) q16.push_back(cyc);
    if (os4 === 1'b1) q4_os.push_back(cyc);
    if (baud4 === 1'b1) q4_baud.push_back(cyc);
    q4_u.push_back(u4 === 1'b1);
    model_step(m16, 16, rst_n, en, valid, int'(dint), int'(dfrac), n16);
    model_step(m4, 4, rst_n, en, valid, int'(dint), int'(dfrac), n4);
    m16 = n16;
    m4  = n4;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic clear_logs();
    q16.delete();
    q4_os.delete();
    q4_baud.delete();
    q4_u.delete();
    u4_base = cyc;
  endtask

  // Apply a divisor straight away: offer it, then hold the generator disabled for two cycles.
  task automatic load_now(input int di, input int df);
    valid = 1'b1; dint = 16'(di); dfrac = 4'(df);
    run_cycle();
    valid = 1'b0; en = 1'b0;
    run(2);
    en = 1'b1;
  endtask

  initial begin
    int n_short, n_long, hi, nb;
    rst_n = 1'b0; en = 1'b1; valid = 1'b0; dint = '0; dfrac = '0;
    @(posedge clk);
    #1;
    model_reset(16, m16);
    model_reset(4, m4);
    run(2);

    // Default divisor after reset: first tick timing and the 325/326 period mix.
    rst_n = 1'b1;
    rel = cyc;
    clear_logs();
    run(10760);
    chk("tick16_count", q16.size() >= 33, 1);
    if (q16.size() >= 33) begin
      chk("first_tick_cycle", q16[0] - rel + 1, 325);
      n_short = 0; n_long = 0;
      for (int i = 0; i < 32; i++) begin
        if (q16[i + 1] - q16[i] == 325) n_short++;
        else if (q16[i + 1] - q16[i] == 326) n_long++;
      end
`ifdef UART_BAUD_GEN_FRAC_EN
      chk("periods_325", n_short, 16);
      chk("periods_326", n_long, 16);
`else
      chk("periods_325", n_short, 32);
      chk("periods_326", n_long, 0);
`endif
    end

    // int=4 frac=0 on the OVERSAMPLE=4 instance: 4-cycle ticks, 16-cycle bits, 8/8 duty.
    load_now(4, 0);
    clear_logs();
    run(64);
    chk("os4_count", q4_os.size() >= 2, 1);
    chk("baud4_count", q4_baud.size() >= 2, 1);
    if (q4_os.size() >= 2) chk("os4_spacing", q4_os[1] - q4_os[0], 4);
    if (q4_baud.size() >= 2) begin
      chk("baud4_spacing", q4_baud[1] - q4_baud[0], 16);
      hi = 0;
      for (int c = q4_baud[0] + 1; c <= q4_baud[1]; c++) hi += int'(q4_u[c - u4_base]);
      chk("u4_high_cycles", hi, 8);
    end

    // int=4 frac=8: 16 ticks span 72 cycles with the fraction, 64 without.
    load_now(4, 8);
    clear_logs();
    run(80);
    chk("frac_tick_count", q16.size() >= 17, 1);
`ifdef UART_BAUD_GEN_FRAC_EN
    if (q16.size() >= 17) chk("frac_16_ticks", q16[16] - q16[0], 72);
`else
    if (q16.size() >= 17) chk("frac_16_ticks", q16[16] - q16[0], 64);
`endif

    // Rejected divisor: error pulse the next cycle, still ready.
    valid = 1'b1; dint = 16'd1; dfrac = 4'd3;
    run_cycle();
    valid = 1'b0;
    chk("err_pulse", bus16.cfg_err, 1'b1);
    chk("ready_after_err", bus16.cfg_ready, 1'b1);
    run(20);

    // int=6 mid-bit, with a repeated offer while pending; takes over at the bit boundary.
    valid = 1'b1; dint = 16'd6; dfrac = 4'd0;
    run_cycle();
    chk("ready_drop", bus16.cfg_ready, 1'b0);
    run(15);
    valid = 1'b0;
    run(300);
    clear_logs();
    run(30);
    chk("int6_count", q16.size() >= 2, 1);
    if (q16.size() >= 2) chk("int6_spacing", q16[1] - q16[0], 6);

    // Enable low for 10 cycles: no ticks.
    en = 1'b0;
    nb = q16.size() + q4_os.size();
    run(10);
    chk("no_ticks_disabled", q16.size() + q4_os.size() - nb, 0);
    en = 1'b1;
    run(20);

    // Reset while a divisor is pending: defaults restored, pending dropped.
    valid = 1'b1; dint = 16'd9; dfrac = 4'd0;
    run_cycle();
    valid = 1'b0; rst_n = 1'b0;
    run_cycle();
    chk("ready_after_reset", bus16.cfg_ready, 1'b1);
    rst_n = 1'b1;
    rel = cyc;
    clear_logs();
    run(330);
    chk("reset_tick_count", q16.size() >= 1, 1);
    if (q16.size() >= 1) chk("reset_first_tick", q16[0] - rel + 1, 325);

    // Random enable, offers and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      en    = ($urandom_range(0, 7) != 0);
      valid = ($urandom_range(0, 5) == 0);
      dint  = 16'($urandom_range(0, 9));
      dfrac = 4'($urandom_range(0, 15));
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
